// File: rtl/core_pipe_pkg.sv
// Shared constants for the five-stage core pipeline control.
// Holds mul/div cycle defaults, the sequencer state encoding and the NOP word.
// No logic; a small helper picks the longer mul/div latency for width checks.
package core_pipe_pkg;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Sequencer state: IDLE while the busy counter is zero, MD_RUN otherwise
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_MD_RUN = 1'b1;

    // Instruction word loaded into pipeline registers on bubble or flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic int cyc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Loadable down-counter tracking how long the mul/div unit stays busy.
// Latency: load takes effect on the next edge; busy is combinational from the count.
// No backpressure: counts down one per cycle and saturates at zero.
module md_busy_cnt
#(
    parameter int CNT_W = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a load wins, otherwise step down until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register; reset clears it immediately so busy drops without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign cnt  = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/bubble/flush sequencing for the five-stage core plus mul/div busy scheduling.
// Latency: stall/bubble/flush are combinational; md_start is one cycle after acceptance.
// Backpressure: a hazard or HI/LO use during mul/div holds F and D and bubbles E.
// Optional PIPE_STALL_CTRL_STATS_EN adds stall_cnt/flush_cnt event counters.
module pipe_stall_ctrl
    import core_pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_use_hazard,
    input  logic        d_md_issue,
    input  logic        d_md_is_div,
    input  logic        d_md_use,
    input  logic        req,
    output logic        stall_f,
    output logic        stall_d,
    output logic        bubble_e,
    output logic        flush_all,
    output logic        md_start,
`ifdef PIPE_STALL_CTRL_STATS_EN
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`else
    output logic        md_busy
`endif
);

    localparam int MAX_CYC = cyc_max(MULT_CYC, DIV_CYC);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    // The busy counter must be able to hold the longest latency
    if ((64'd1 << CNT_W) <= 64'(MAX_CYC)) begin : g_cnt_w_check
        $error("CNT_W too narrow for mul/div latency");
    end

    logic             stall;
    logic             accept;
    logic             md_start_q;
    logic             md_start_d;
    logic             is_div_q;
    logic             is_div_d;
    logic             cnt_busy;
    logic             state;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] load_val;

    // State follows the counter: any nonzero count means the unit is running
    assign state = (md_cnt != '0) ? ST_MD_RUN : ST_IDLE;

    // Hazard combining; an exception overrides every hold so the clear can propagate
    always_comb begin
        stall     = ld_use_hazard | (d_md_use & ((state == ST_MD_RUN) | md_start_q));
        accept    = d_md_issue & ~stall & ~req;
        stall_f   = stall & ~req;
        stall_d   = stall & ~req;
        bubble_e  = stall & ~req;
        flush_all = req;
    end

    // Acceptance latches the op kind; it is only consumed in the md_start cycle
    always_comb begin
        md_start_d = accept;
        is_div_d   = accept ? d_md_is_div : is_div_q;
    end

    // Start pulse and op-kind registers; an md_start already in E is never revoked by req
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_start_q <= 1'b0;
            is_div_q   <= 1'b0;
        end else begin
            md_start_q <= md_start_d;
            is_div_q   <= is_div_d;
        end
    end

    assign load_val = is_div_q ? DIV_LD : MULT_LD;

    // Loaded during the start cycle so busy rises on the following cycle
    md_busy_cnt #(
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (md_start_q),
        .load_val (load_val),
        .busy     (cnt_busy),
        .cnt      (md_cnt)
    );

    assign md_start = md_start_q;
    assign md_busy  = cnt_busy;

`ifdef PIPE_STALL_CTRL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Event counters: stalls not overridden by an exception, and exception clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !req) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (req) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
